// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
// Groups the producer write side and the uart_tx read side of the byte FIFO.
//   wr_en, wr_data, clr_ovf   : producer -> FIFO
//   full, almost_full, empty,
//   count, overflow           : FIFO -> producer status
//   tx_data, tx_valid         : FIFO -> uart_tx
//   tx_ready                  : uart_tx -> FIFO
// master: the side that drives the FIFO inputs (producer plus transmitter).
// slave : the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              clr_ovf;
    logic              tx_ready;

    logic              full;
    logic              almost_full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_ready,
        input  full, almost_full, empty, count, overflow, tx_data, tx_valid
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_ready,
        output full, almost_full, empty, count, overflow, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer feeding uart_tx. Bytes pushed at clock rate are held in a
// DEPTH-entry register array and offered first-word-fall-through on a
// valid/ready handshake.
// Ports:
//   clk  : single rising-edge clock (shared with uart_tx)
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_fifo_if.slave (write strobe/data, overflow clear,
//          status outputs, tx_data/tx_valid/tx_ready handshake)
module uart_tx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = CW - 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Storage is deliberately left out of reset; empty masks stale contents.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;

    always_comb begin
        // Status is decoded from the registered count only, so a push in
        // the same cycle as a pop from a full FIFO is still rejected.
        full_w  = (count_q == DEPTH_C);
        empty_w = (count_q == '0);
        push    = bus.wr_en && !full_w;
        pop     = !empty_w && bus.tx_ready;

        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        // Pointers are log2(DEPTH) bits wide, so wrap is the natural overflow.
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (pop) begin
            rp_d = rp_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Set has priority over clear so a rejected write is never lost.
        if (bus.wr_en && full_w) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= bus.wr_data;
        end
    end

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almost_full = (count_q >= AF_C);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.tx_valid    = !empty_w;
    assign bus.tx_data     = empty_w ? '0 : mem[rp_q];
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer sitting directly upstream of `uart_tx`. A producer pushes bytes at clock rate with a write strobe. The FIFO presents them one at a time to the transmitter over a valid/ready handshake, absorbing bursts while the serialiser works at bit rate. It exposes occupancy, full/almost-full status and a sticky overflow flag for the producer.

## Interface

- `DATA_W`, 8, byte width; must match `uart_tx` `tx_data`.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `AF_LEVEL`, 12, `almost_full` asserts when `count >= AF_LEVEL`; range 1..DEPTH.

Ports (`CW = $clog2(DEPTH)+1`):

- `clk`, in, 1: single clock, rising edge; same clock as `uart_tx`.
- `rst`, in, 1: reset, asynchronous, active-high.
- `wr_en`, in, 1: producer write strobe, one byte per cycle.
- `wr_data`, in, DATA_W: byte to write.
- `full`, out, 1: `count == DEPTH`.
- `almost_full`, out, 1: `count >= AF_LEVEL`.
- `empty`, out, 1: `count == 0`.
- `count`, out, CW: current occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky; set by a rejected write.
- `clr_ovf`, in, 1: clears `overflow`.
- `tx_data`, out, DATA_W: head byte to `uart_tx`.
- `tx_valid`, out, 1: head byte is valid (equals `!empty`).
- `tx_ready`, in, 1: `uart_tx` accepts a byte this cycle.

## Operation

- Storage: DEPTH × DATA_W register array; write pointer `wp` and read pointer `rp`, each CW-1 bits, wrapping modulo DEPTH; separate `count` register.
- Push:
  - accepted when `wr_en && !full`, with `full` sampled as the registered value at the start of the cycle;
  - on accept: `mem[wp] <= wr_data`, `wp <= wp+1`.
- Pop:
  - occurs when `tx_valid && tx_ready`;
  - on pop: `rp <= rp+1`.
- First-word-fall-through:
  - `tx_data = mem[rp]` while `!empty`;
  - `tx_data` is forced to 0 while `empty`.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Simultaneous push and pop:
  - FIFO non-empty and not full: both occur, `count` unchanged.
  - FIFO full: pop occurs, push is rejected (`full` was set at cycle start), `overflow` sets. There is no same-cycle pass-through when full.
  - FIFO empty: push occurs, no pop (`tx_valid` = 0). There is no bypass: the byte appears on `tx_data` the next cycle.
- Overflow:
  - `wr_en && full` sets `overflow` on the next edge;
  - `clr_ovf` clears it;
  - set and clear in the same cycle leaves `overflow` = 1 (set wins);
  - the rejected byte is discarded, and FIFO contents and pointers are untouched.
- `tx_ready` while empty: ignored; no pointer or count change.
- Handshake stability: while `tx_valid && !tx_ready`, `tx_data` and `tx_valid` hold. Writes never alter the head entry.
- Reset (async, active-high), taking effect immediately, including mid-transfer:
  - `wp = rp = 0`, `count = 0`, `overflow = 0`;
  - hence `empty = 1`, `full = 0`, `almost_full = 0`, `tx_valid = 0`, `tx_data = 0`;
  - array contents are not reset; they are masked by `empty`.
  - Bytes in flight are lost. `uart_tx` is reset by the same `rst`.

## Timing

- Write-to-valid latency:
  - 1 cycle from the accepting edge when empty;
  - otherwise the byte waits behind earlier entries.
- Pop-to-next-head: the new `tx_data` is valid combinationally in the cycle after the popping edge. Back-to-back pops are sustainable, one per cycle.
- All status outputs (`full`, `empty`, `almost_full`, `count`, `overflow`) are registered or decoded from registered `count`/flags. They reflect the state after the last edge, with no combinational path from `wr_en` or `tx_ready`.
- `tx_valid` has no combinational dependency on `tx_ready`.
- Throughput: 1 push and 1 pop per cycle; full is the steady state when the producer outruns `uart_tx`.

## Test plan

- Reset/idle:
  - assert `rst` mid-cycle while `count` = 5 → outputs go immediately to `count` = 0, `empty` = 1, `tx_valid` = 0, `tx_data` = 00, `overflow` = 0;
  - holding `tx_ready` = 1 while empty → no change.
- Ordering:
  - with `tx_ready` = 0, write 15, 4d, 03, a4 → `count` = 4, `tx_data` = 15;
  - then `tx_ready` = 1 for 4 cycles → `tx_data` sequence 15, 4d, 03, a4, then `empty` = 1.
- Fill/overflow (DEPTH = 16, AF_LEVEL = 12):
  - 12th write → `almost_full` = 1;
  - 16th → `full` = 1;
  - 17th write (ea) → `overflow` = 1, `count` = 16, ea never appears on `tx_data`;
  - `clr_ovf` → `overflow` = 0;
  - `clr_ovf` together with another write while full → `overflow` stays 1.
- Full simultaneous push and pop:
  - full, `wr_en` = 1 and `tx_ready` = 1 in the same cycle → `count` = 15, `overflow` = 1, written byte absent from the output stream.
- Wrap-around:
  - stream 40 bytes (00..27) with `wr_en` and `tx_ready` both held high (`tx_ready` high from one cycle after the first write) → `count` stays at 1, output equals input in order across pointer wraps, no overflow.
- Paired with `uart_tx`:
  - burst-write 11 bytes (15, 4d, 03, a4, 2e, c8, fa, 22, 14, 32, ea) at one per cycle;
  - `uart_rx` on a loopback line recovers all 11 in order, with zero mismatches and `overflow` = 0.
